// File: rtl/fg_wave_scheduler_if.sv
// Configuration handshake and sample-sequencing bundle for fg_wave_scheduler.
// The master drives run control and configuration; the slave (scheduler) drives status and timing.
interface fg_wave_scheduler_if #(
  parameter int unsigned DIV_W = 16
) ();
  logic             run_en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_wave_sel;
  logic [DIV_W-1:0] cfg_div;
  logic [11:0]      cfg_max;
  logic [11:0]      cfg_min;
  logic             cfg_err;
  logic             sample_tick;
  logic [6:0]       phase_idx;
  logic             period_start;
  logic [1:0]       wave_sel;
  logic [11:0]      maximum;
  logic [11:0]      minimum;
  logic             active;

  modport master (
    output run_en, cfg_valid, cfg_wave_sel, cfg_div, cfg_max, cfg_min,
    input  cfg_ready, cfg_err, sample_tick, phase_idx, period_start, wave_sel, maximum, minimum,
           active
  );

  modport slave (
    input  run_en, cfg_valid, cfg_wave_sel, cfg_div, cfg_max, cfg_min,
    output cfg_ready, cfg_err, sample_tick, phase_idx, period_start, wave_sel, maximum, minimum,
           active
  );
endinterface

// File: rtl/fg_wave_scheduler.sv
// Sample-strobe / phase sequencer that applies new waveform configs only at period boundaries.
// Optional FG_SWEEP_EN: divider steps down by SWEEP_STEP each period, reloading the accepted cfg_div.
module fg_wave_scheduler #(
  parameter int unsigned TABLE_LEN  = 100,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned SWEEP_STEP = 1
) (
  input logic                 clock,
  input logic                 reset_n,
  fg_wave_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPending} state_e;

  localparam logic [6:0] PhaseLast = 7'(TABLE_LEN - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [6:0]       phase_q, phase_d;
  logic [1:0]       sel_q, sel_d, sh_sel_q, sh_sel_d;
  logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
  logic [11:0]      max_q, max_d, sh_max_q, sh_max_d;
  logic [11:0]      min_q, min_d, sh_min_q, sh_min_d;
  logic             active_q, active_d;
  logic             err_q, err_d;

  logic [DIV_W-1:0] eff_div;
  logic             running, xfer, cfg_ok, tick, wrap;

  assign running = (state_q == StRun) || (state_q == StPending);
  assign xfer    = bus.cfg_valid && (state_q != StPending);
  assign cfg_ok  = (bus.cfg_div != '0) && (bus.cfg_max > bus.cfg_min);
  assign tick    = running && bus.run_en && (cnt_q == (eff_div - DIV_W'(1)));
  assign wrap    = tick && (phase_q == PhaseLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sel_d    = sel_q;
    div_d    = div_q;
    max_d    = max_q;
    min_d    = min_q;
    sh_sel_d = sh_sel_q;
    sh_div_d = sh_div_q;
    sh_max_d = sh_max_q;
    sh_min_d = sh_min_q;
    active_d = active_q;
    err_d    = 1'b0;

    if (running && bus.run_en) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = wrap ? 7'd0 : phase_q + 7'd1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // A pending config takes over exactly on the edge that produces index 0.
    if ((state_q == StPending) && wrap) begin
      sel_d   = sh_sel_q;
      div_d   = sh_div_q;
      max_d   = sh_max_q;
      min_d   = sh_min_q;
      cnt_d   = '0;
      phase_d = 7'd0;
      state_d = StRun;
    end

    if (xfer) begin
      if (!cfg_ok) begin
        err_d = 1'b1;
      end else if (state_q == StIdle) begin
        sel_d    = bus.cfg_wave_sel;
        div_d    = bus.cfg_div;
        max_d    = bus.cfg_max;
        min_d    = bus.cfg_min;
        active_d = 1'b1;
        cnt_d    = '0;
        phase_d  = 7'd0;
        state_d  = StRun;
      end else begin
        sh_sel_d = bus.cfg_wave_sel;
        sh_div_d = bus.cfg_div;
        sh_max_d = bus.cfg_max;
        sh_min_d = bus.cfg_min;
        state_d  = StPending;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      phase_q  <= '0;
      sel_q    <= '0;
      div_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      sh_sel_q <= '0;
      sh_div_q <= '0;
      sh_max_q <= '0;
      sh_min_q <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      div_q    <= div_d;
      max_q    <= max_d;
      min_q    <= min_d;
      sh_sel_q <= sh_sel_d;
      sh_div_q <= sh_div_d;
      sh_max_q <= sh_max_d;
      sh_min_q <= sh_min_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

`ifdef FG_SWEEP_EN
  localparam logic [DIV_W-1:0] Step = DIV_W'(SWEEP_STEP);

  logic [DIV_W-1:0] eff_div_q, eff_div_d;

  always_comb begin
    eff_div_d = eff_div_q;
    if ((state_q == StPending) && wrap) begin
      eff_div_d = sh_div_q;
    end else if (wrap) begin
      // Stepping below 1 restarts the sweep from the accepted divider.
      eff_div_d = (eff_div_q > Step) ? eff_div_q - Step : div_q;
    end
    if (xfer && cfg_ok && (state_q == StIdle)) begin
      eff_div_d = bus.cfg_div;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eff_div_q <= '0;
    end else begin
      eff_div_q <= eff_div_d;
    end
  end

  assign eff_div = eff_div_q;
`else
  assign eff_div = div_q;
`endif

  assign bus.cfg_ready    = (state_q != StPending);
  assign bus.cfg_err      = err_q;
  assign bus.sample_tick  = tick;
  assign bus.period_start = wrap;
  assign bus.phase_idx    = phase_q;
  assign bus.wave_sel     = sel_q;
  assign bus.maximum      = max_q;
  assign bus.minimum      = min_q;
  assign bus.active       = active_q;

endmodule

// File: tb/tb_fg_wave_scheduler.sv
// Self-checking bench for fg_wave_scheduler: rejection table, tick timing, pending apply,
// pause, reset discard and divider sweep; applied configs are scoreboarded.
module tb_fg_wave_scheduler;
  localparam int unsigned TableLen = 100;
  localparam int unsigned DivW     = 16;
  localparam int          Limit    = 5000;

  typedef struct {
    logic [1:0]      sel;
    logic [DivW-1:0] div;
    logic [11:0]     maxv;
    logic [11:0]     minv;
  } cfg_t;

  typedef struct {
    cfg_t cfg;
    logic exp_err;
    logic exp_active;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  cfg_t exp_q[$];

  fg_wave_scheduler_if #(.DIV_W(DivW)) bus ();

  fg_wave_scheduler #(
    .TABLE_LEN (TableLen),
    .DIV_W     (DivW),
    .SWEEP_STEP(1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Call just after a posedge; returns just after the transfer edge.
  task automatic offer(input cfg_t c);
    bus.cfg_valid    = 1'b1;
    bus.cfg_wave_sel = c.sel;
    bus.cfg_div      = c.div;
    bus.cfg_max      = c.maxv;
    bus.cfg_min      = c.minv;
    @(posedge clock);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  // Counts negedges until one shows sample_tick (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.sample_tick !== 1'b1 && n < Limit);
    if (n >= Limit) check("tick_timeout", int'(bus.sample_tick), 1);
  endtask

  // Scoreboard: every change of the applied configuration must match the next expected one.
  logic [26:0] prev_cfg = '0;
  always @(negedge clock) begin
    logic [26:0] cur;
    cfg_t e;
    cur = {bus.active, bus.wave_sel, bus.maximum, bus.minimum};
    if (bus.active && cur != prev_cfg) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_apply", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_wave_sel", int'(bus.wave_sel), int'(e.sel));
        check("sb_maximum", int'(bus.maximum), int'(e.maxv));
        check("sb_minimum", int'(bus.minimum), int'(e.minv));
      end
    end
    prev_cfg = cur;
  end

  initial begin
    vec_t vecs[5];
    cfg_t c1, c3, c5, c6, bad_c;
    int n, bad, cnt, total;
    int sweep_exp[3];

    vecs[0] = '{cfg: '{sel: 2'd0, div: 16'd4, maxv: 12'd100, minv: 12'd100},
                exp_err: 1'b1, exp_active: 1'b0};
    vecs[1] = '{cfg: '{sel: 2'd0, div: 16'd0, maxv: 12'd4000, minv: 12'd100},
                exp_err: 1'b1, exp_active: 1'b0};
    vecs[2] = '{cfg: '{sel: 2'd1, div: 16'd9, maxv: 12'd50, minv: 12'd60},
                exp_err: 1'b1, exp_active: 1'b0};
    vecs[3] = '{cfg: '{sel: 2'd2, div: 16'd0, maxv: 12'd0, minv: 12'd0},
                exp_err: 1'b1, exp_active: 1'b0};
    vecs[4] = '{cfg: '{sel: 2'd3, div: 16'd1, maxv: 12'hFFF, minv: 12'hFFF},
                exp_err: 1'b1, exp_active: 1'b0};
    c1    = '{sel: 2'd0, div: 16'd4, maxv: 12'd4000, minv: 12'd100};
    c3    = '{sel: 2'd1, div: 16'd2, maxv: 12'd3000, minv: 12'd200};
    c5    = '{sel: 2'd2, div: 16'd6, maxv: 12'd2000, minv: 12'd1000};
    c6    = '{sel: 2'd3, div: 16'd3, maxv: 12'hFFF, minv: 12'd0};
    bad_c = '{sel: 2'd2, div: 16'd0, maxv: 12'd900, minv: 12'd10};
`ifdef FG_SWEEP_EN
    sweep_exp = '{3, 2, 1};
`else
    sweep_exp = '{3, 3, 3};
`endif

    bus.run_en = 1'b1; bus.cfg_valid = 1'b0; bus.cfg_wave_sel = '0;
    bus.cfg_div = '0; bus.cfg_max = '0; bus.cfg_min = '0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_cfg_ready", int'(bus.cfg_ready), 1);
    check("rst_active", int'(bus.active), 0);
    check("rst_phase", int'(bus.phase_idx), 0);
    check("rst_outs", int'({bus.cfg_err, bus.sample_tick, bus.period_start, bus.wave_sel,
                            bus.maximum, bus.minimum}), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Rejection table from IDLE
    foreach (vecs[i]) begin
      if (!vecs[i].exp_err) exp_q.push_back(vecs[i].cfg);
      offer(vecs[i].cfg);
      @(negedge clock);
      check($sformatf("vec%0d_err", i), int'(bus.cfg_err), int'(vecs[i].exp_err));
      check($sformatf("vec%0d_active", i), int'(bus.active), int'(vecs[i].exp_active));
      check($sformatf("vec%0d_ready", i), int'(bus.cfg_ready), 1);
      @(negedge clock);
      check($sformatf("vec%0d_err_pulse", i), int'(bus.cfg_err), 0);
      @(posedge clock); #1;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.sample_tick || bus.active) bad++;
    end
    check("idle_no_ticks", bad, 0);
    @(posedge clock); #1;

    // Basic run: div=4, one full period
    exp_q.push_back(c1);
    offer(c1);
    wait_tick(n);
    check("t1_first_latency", n, 4);
    check("t1_first_phase", int'(bus.phase_idx), 0);
    check("t1_first_pstart", int'(bus.period_start), 0);
    total = n; bad = 0;
    for (int j = 1; j < 100; j++) begin
      wait_tick(n);
      total += n;
      if (n != 4) bad++;
      if (int'(bus.phase_idx) != j) bad++;
      if (bus.period_start != (j == 99)) bad++;
    end
    check("t1_tick_pattern", bad, 0);
    check("t1_period_clocks", total, 400);
    @(negedge clock);
    check("t1_wrap_phase", int'(bus.phase_idx), 0);

    // Rejected offer while running leaves the active config alone
    @(posedge clock); #1;
    offer(bad_c);
    @(negedge clock);
    check("run_rej_err", int'(bus.cfg_err), 1);
    check("run_rej_ready", int'(bus.cfg_ready), 1);
    check("run_rej_max", int'(bus.maximum), 4000);

    // Pause at phase 50 mid-count
    for (int k = 0; k < 200; k++) begin
      wait_tick(n);
      if (bus.phase_idx == 7'd49) break;
    end
    check("t4_found49", int'(bus.phase_idx), 49);
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.run_en = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.sample_tick || bus.phase_idx != 7'd50) bad++;
    end
    check("t4_hold", bad, 0);
    @(posedge clock); #1;
    bus.run_en = 1'b1;
    wait_tick(n);
    check("t4_resume_latency", n, 3);
    check("t4_resume_phase", int'(bus.phase_idx), 50);

    // Pending reconfiguration at phase 37
    for (int k = 0; k < 200; k++) begin
      wait_tick(n);
      if (bus.phase_idx == 7'd36) break;
    end
    check("t3_found36", int'(bus.phase_idx), 36);
    @(posedge clock); #1;
    exp_q.push_back(c3);
    offer(c3);
    cnt = 0; bad = 0;
    do begin
      wait_tick(n);
      cnt++;
      if (bus.cfg_ready !== 1'b0 || bus.wave_sel !== 2'd0) bad++;
      if (cnt > 1 && n != 4) bad++;
    end while (bus.period_start !== 1'b1 && cnt < 200);
    check("t3_old_ticks", cnt, 63);
    check("t3_old_pattern", bad, 0);
    check("t3_wrap_phase", int'(bus.phase_idx), 99);
    wait_tick(n);
    check("t3_new_gap", n, 2);
    check("t3_new_sel", int'(bus.wave_sel), 1);
    check("t3_new_ready", int'(bus.cfg_ready), 1);
    check("t3_new_phase", int'(bus.phase_idx), 0);
    bad = 0;
    repeat (3) begin
      wait_tick(n);
      if (n != 2) bad++;
    end
    check("t3_new_gaps", bad, 0);

    // Reset while pending discards the shadow config
    @(posedge clock); #1;
    offer(c5);
    @(negedge clock);
    check("t5_pending_ready", int'(bus.cfg_ready), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_active", int'(bus.active), 0);
    check("t5_rst_ready", int'(bus.cfg_ready), 1);
    check("t5_rst_outs", int'({bus.cfg_err, bus.sample_tick, bus.period_start, bus.wave_sel,
                               bus.maximum, bus.minimum, bus.phase_idx}), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clock);
      if (bus.sample_tick || bus.active || bus.wave_sel != 2'd0 || bus.maximum != 12'd0) bad++;
    end
    check("t5_stays_idle", bad, 0);

    // Divider per period (sweep when enabled)
    @(posedge clock); #1;
    exp_q.push_back(c6);
    offer(c6);
    for (int p = 0; p < 4; p++) begin
      total = 0; bad = 0;
      for (int t = 0; t < 100; t++) begin
        wait_tick(n);
        total += n;
        if (bus.period_start != (t == 99)) bad++;
      end
      check($sformatf("t6_period%0d_clocks", p), total, 100 * sweep_exp[p % 3]);
      check($sformatf("t6_period%0d_pstart", p), bad, 0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
